mem_bus_arbiter: RTL

Two-port arbiter and sequencer for the 256×8 unified-bus memory. It accepts word requests from the instruction-fetch port (p0) and the data port (p1) and grants one at a time. It issues the memory start/rw/address command, drives or releases `uniBus`, and returns read data with a one-cycle acknowledge. It sits between the CPU core and the memory and is the only master of the memory command lines and of CPU-side `uniBus` drive.

---
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter/sequencer for the 256x8 unified-bus memory: IDLE->ISSUE->ACCESS->RESP, 4 cycles per access.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise p0 has fixed priority.
module mem_bus_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          p0_req,
  input  logic          p1_req,
  input  logic          p0_rw,
  input  logic          p1_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p0_wdata,
  input  logic [DW-1:0] p1_wdata,
  output logic          p0_ack,
  output logic          p1_ack,
  output logic [DW-1:0] p0_rdata,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_start,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  inout  logic [DW-1:0] uniBus,
  output logic          busy,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          rw_q, rw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          pick_p1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_q = 1 means p1 was granted most recently; a tie goes to the other port
  logic last_q, last_d;

  always_comb begin
    pick_p1 = p1_req && (!p0_req || !last_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    pick_p1 = p1_req && !p0_req;
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d = ISSUE;
          grant_d = pick_p1 ? 2'b10 : 2'b01;
          rw_d    = pick_p1 ? p1_rw    : p0_rw;
          addr_d  = pick_p1 ? p1_addr  : p0_addr;
          wdata_d = pick_p1 ? p1_wdata : p0_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d  = pick_p1;
`endif
        end
      end
      ISSUE: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Memory drives the bus during a read ACCESS; capture at the closing edge
        if (rw_q) begin
          if (grant_q[1]) begin
            p1_rdata_d = uniBus;
          end else begin
            p0_rdata_d = uniBus;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign uniBus    = (state_q == ACCESS && !rw_q) ? wdata_q : 'z;
  assign mem_start = (state_q == ISSUE);
  assign mem_rw    = rw_q;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign p0_ack    = (state_q == RESP) && grant_q[0];
  assign p1_ack    = (state_q == RESP) && grant_q[1];
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule
